// File: rtl/cskip_adder_pipe.sv
// Pipelined carry-skip adder: WIDTH-bit A+B+cin built from BLOCK-bit ripple blocks with skip bypass,
// BLOCKS_PER_STAGE blocks per register stage, valid/ready handshake on both sides.
module cskip_adder_pipe #(
  parameter int  WIDTH            = 16,
  parameter int  BLOCK            = 4,
  parameter int  BLOCKS_PER_STAGE = 2,
  localparam int NBLK             = WIDTH / BLOCK,
  localparam int NSTAGE           = (NBLK + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add_term1,
  input  logic [WIDTH-1:0] i_add_term2,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf,
  output logic [NBLK-1:0]  o_skip
);

  if (BLOCK < 1 || BLOCKS_PER_STAGE < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("cskip_adder_pipe: WIDTH must be a positive multiple of BLOCK, BLOCKS_PER_STAGE >= 1");
  end

  logic [NSTAGE-1:0] v_q, v_d, c_q, c_d, ovf_q, ovf_d, en;
  logic [WIDTH-1:0]  a_q   [NSTAGE];
  logic [WIDTH-1:0]  a_d   [NSTAGE];
  logic [WIDTH-1:0]  b_q   [NSTAGE];
  logic [WIDTH-1:0]  b_d   [NSTAGE];
  logic [WIDTH-1:0]  res_q [NSTAGE];
  logic [WIDTH-1:0]  res_d [NSTAGE];
  logic [NBLK-1:0]   skip_q[NSTAGE];
  logic [NBLK-1:0]   skip_d[NSTAGE];

  // A stage may load when it is empty or anything downstream of it can advance.
  always_comb begin
    logic e;
    e  = 1'b0;
    en = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      e = i_ready;
      for (int j = k; j < NSTAGE; j++) begin
        e = e | ~v_q[j];
      end
      en[k] = e;
    end
  end

  assign o_ready = en[0];

  // Running values start at the ports and are replaced by each stage's register for the next stage.
  always_comb begin
    logic [WIDTH-1:0] ain, bin, res;
    logic [NBLK-1:0]  skip;
    logic             vin, c, ovf, rc, p, cmsb;
    ain  = i_add_term1;
    bin  = i_add_term2;
    c    = i_cin;
    vin  = i_valid;
    res  = '0;
    skip = '0;
    ovf  = 1'b0;
    rc   = 1'b0;
    p    = 1'b0;
    cmsb = 1'b0;
    for (int k = 0; k < NSTAGE; k++) begin
      for (int blk = 0; blk < NBLK; blk++) begin
        if (blk / BLOCKS_PER_STAGE == k) begin
          rc = c;
          p  = 1'b1;
          for (int j = 0; j < BLOCK; j++) begin
            if (blk * BLOCK + j == WIDTH - 1) cmsb = rc;
            res[blk*BLOCK+j] = ain[blk*BLOCK+j] ^ bin[blk*BLOCK+j] ^ rc;
            p  = p & (ain[blk*BLOCK+j] ^ bin[blk*BLOCK+j]);
            rc = (ain[blk*BLOCK+j] & bin[blk*BLOCK+j]) |
                 (rc & (ain[blk*BLOCK+j] ^ bin[blk*BLOCK+j]));
          end
          skip[blk] = p;
          c = p ? c : rc;
          if (blk == NBLK - 1) ovf = cmsb ^ c;
        end
      end
      v_d[k]    = vin;
      a_d[k]    = ain;
      b_d[k]    = bin;
      c_d[k]    = c;
      res_d[k]  = res;
      skip_d[k] = skip;
      ovf_d[k]  = ovf;
      vin  = v_q[k];
      ain  = a_q[k];
      bin  = b_q[k];
      c    = c_q[k];
      res  = res_q[k];
      skip = skip_q[k];
      ovf  = ovf_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k]    <= '0;
        b_q[k]    <= '0;
        res_q[k]  <= '0;
        skip_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (en[k]) begin
          v_q[k]    <= v_d[k];
          c_q[k]    <= c_d[k];
          ovf_q[k]  <= ovf_d[k];
          a_q[k]    <= a_d[k];
          b_q[k]    <= b_d[k];
          res_q[k]  <= res_d[k];
          skip_q[k] <= skip_d[k];
        end
      end
    end
  end

  assign o_valid  = v_q[NSTAGE-1];
  assign o_result = res_q[NSTAGE-1];
  assign o_cout   = c_q[NSTAGE-1];
  assign o_ovf    = ovf_q[NSTAGE-1];
  assign o_skip   = skip_q[NSTAGE-1];

endmodule

// File: tb/tb_cskip_adder_pipe.sv
// Directed-table and random bench for cskip_adder_pipe (WIDTH=16, BLOCK=4, BLOCKS_PER_STAGE=2).
module tb_cskip_adder_pipe;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic [3:0]  skip;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic [3:0]  skip;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst_n, i_valid, o_ready, i_cin, o_valid, i_ready, o_cout, o_ovf;
  logic [15:0] i_add_term1, i_add_term2, o_result;
  logic [3:0]  o_skip;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic acc_last = 1'b0;
  exp_t sb[$];
  exp_t pend;
  vec_t tbl[7];

  always #5 clk = ~clk;

  cskip_adder_pipe #(.WIDTH(16), .BLOCK(4), .BLOCKS_PER_STAGE(2)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_add_term1(i_add_term1), .i_add_term2(i_add_term2), .i_cin(i_cin),
    .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_cout(o_cout),
    .o_ovf(o_ovf), .o_skip(o_skip)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    exp_t        e;
    logic [16:0] s;
    s      = {1'b0, a} + {1'b0, b} + {16'b0, cin};
    e.res  = s[15:0];
    e.cout = s[16];
    e.ovf  = (a[15] == b[15]) && (s[15] != a[15]);
    for (int k = 0; k < 4; k++) e.skip[k] = &(a[k*4 +: 4] ^ b[k*4 +: 4]);
    e.acc  = 0;
    e.lat  = 0;
    return e;
  endfunction

  task automatic set_vec(input vec_t v, input int lat);
    i_add_term1 = v.a;
    i_add_term2 = v.b;
    i_cin       = v.cin;
    pend.res    = v.res;
    pend.cout   = v.cout;
    pend.ovf    = v.ovf;
    pend.skip   = v.skip;
    pend.acc    = 0;
    pend.lat    = lat;
  endtask

  // Called just after a falling edge with inputs settled; records what the next rising edge transfers.
  task automatic cycle();
    exp_t e;
    #1;
    if (i_valid && o_ready) begin
      e     = pend;
      e.acc = cyc;
      sb.push_back(e);
    end
    if (o_valid && i_ready) begin
      check("output_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("result", o_result, e.res);
        check("cout", o_cout, e.cout);
        check("ovf", o_ovf, e.ovf);
        check("skip", o_skip, e.skip);
        if (e.lat != 0) check("latency", cyc - e.acc, e.lat);
      end
    end
    acc_last = i_valid && o_ready;
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) cycle();
    check("drain_empty", sb.size(), 0);
    #1;
    check("idle_valid", o_valid, 0);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_state();
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_cout", o_cout, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_skip", o_skip, 0);
    check("rst_ready", o_ready, 1);
  endtask

  initial begin
    int ops;
    vec_t v;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b0110};
    tbl[2] = '{16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0, 4'b1111};
    tbl[3] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 4'b0000};
    tbl[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0010};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 4'b0000};
    tbl[6] = '{16'h0003, 16'h0004, 1'b1, 16'h0008, 1'b0, 1'b0, 4'b0000};

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_add_term1 = '0;
    i_add_term2 = '0;
    i_cin = 1'b0;
    pend = model(16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    check_reset_state();
    @(negedge clk);
    cyc++;

    // Single operations with latency check
    for (int i = 0; i < 3; i++) begin
      set_vec(tbl[i], 2);
      i_valid = 1'b1;
      i_ready = 1'b1;
      cycle();
      drain();
    end

    // Back-to-back stream: each at fixed latency means consecutive outputs
    i_ready = 1'b1;
    for (int i = 3; i < 7; i++) begin
      set_vec(tbl[i], 2);
      i_valid = 1'b1;
      cycle();
    end
    drain();

    // Output stall with full pipeline
    i_ready = 1'b0;
    i_valid = 1'b1;
    v = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 4'b0000};
    set_vec(v, 0);
    cycle();
    v = '{16'h0002, 16'h0002, 1'b0, 16'h0004, 1'b0, 1'b0, 4'b0000};
    set_vec(v, 0);
    cycle();
    v = '{16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0, 4'b0000};
    set_vec(v, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", o_ready, 0);
      check("stall_valid", o_valid, 1);
      check("stall_result", o_result, 16'h0002);
      cycle();
    end
    i_ready = 1'b1;
    cycle();
    drain();

    // Reset with two operations in flight
    i_ready = 1'b0;
    i_valid = 1'b1;
    set_vec(tbl[3], 0);
    cycle();
    set_vec(tbl[4], 0);
    cycle();
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge clk);
    cyc++;
    i_rst_n = 1'b1;
    sb.delete();
    check_reset_state();
    set_vec(tbl[0], 2);
    i_valid = 1'b1;
    i_ready = 1'b1;
    cycle();
    drain();

    // Random traffic against the arithmetic reference
    ops = 0;
    i_valid = 1'b0;
    acc_last = 1'b0;
    for (int n = 0; n < 20000 && ops < 2000; n++) begin
      if (!i_valid || acc_last) begin
        i_valid     = ($urandom_range(0, 3) != 0);
        i_add_term1 = 16'($urandom());
        i_add_term2 = 16'($urandom());
        i_cin       = 1'($urandom_range(0, 1));
        pend        = model(i_add_term1, i_add_term2, i_cin);
      end
      i_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc_last) ops++;
    end
    check("random_ops_done", ops, 2000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
